// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch line-fill block.
// Optional line-buffer hit path is enabled with IFETCH_LINEBUF_EN.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_FILL    = 2'd2,
        ST_DELIVER = 2'd3
    } ifetch_state_t;

    localparam logic [12:0] TAG_READ      = 13'h0001;
    localparam int          LINE_BYTES    = 64;
    localparam int          LINE_OFF_BITS = 6;

    // Pick the 32-bit instruction half of a 64-bit beat (little-endian).
    function automatic logic [31:0] sel_word(input logic [63:0] beat, input logic hi);
        sel_word = hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/ifetch_linebuf.sv
// Line buffer: 8 x 64-bit storage, valid/tag, and word-select read port.
// With IFETCH_LINEBUF_EN the stored tag is compared to i_tag to report a hit;
// without it the compare is absent and o_hit is tied low.
module ifetch_linebuf
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_wr_en,
    input  logic [2:0]  i_wr_idx,
    input  logic [63:0] i_wr_data,
    input  logic        i_inval,
    input  logic        i_install,
    input  logic [57:0] i_tag,
    input  logic [2:0]  i_rd_idx,
    input  logic        i_rd_hi,
    output logic [31:0] o_rd_word,
    output logic        o_hit
);

    logic [63:0] r_line [8];
    logic        r_valid;
    logic [57:0] r_tag;

    // Beat storage; contents are only trusted once the line is marked valid.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_line[i_wr_idx] <= i_wr_data;
        end
    end

    // Valid/tag: cleared when a new fill starts, set on the last beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_tag   <= 58'd0;
        end else if (i_inval) begin
            r_valid <= 1'b0;
        end else if (i_install) begin
            r_valid <= 1'b1;
            r_tag   <= i_tag;
        end
    end

    assign o_rd_word = sel_word(r_line[i_rd_idx], i_rd_hi);

`ifdef IFETCH_LINEBUF_EN
    assign o_hit = r_valid && (r_tag == i_tag);
`else
    logic w_unused_tag;
    assign w_unused_tag = ^{r_valid, r_tag};
    assign o_hit = 1'b0;
`endif

endmodule

// File: rtl/ifetch_line_fill.sv
// Instruction fetch responder: fills a 64-byte line over the shared bus and
// returns the addressed 32-bit instruction with sig_recvd.
// Build option IFETCH_LINEBUF_EN lets a fetch hitting the buffered line skip the bus.
module ifetch_line_fill
    import ifetch_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [63:0]               pc_in,
    input  logic                      fetch_en,
    input  logic                      stall,
    input  logic                      flush,
    output logic [31:0]               instr_out,
    output logic [63:0]               instr_pc,
    output logic                      sig_recvd,
    output logic                      bus_reqcyc,
    output logic [63:0]               bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_REQ     = ST_REQ;
    localparam logic [1:0] S_FILL    = ST_FILL;
    localparam logic [1:0] S_DELIVER = ST_DELIVER;

    logic [1:0]               r_state;
    logic [1:0]               w_next;
    logic [63:0]              r_cur_pc;
    logic [2:0]               r_beat_cnt;
    logic                     r_flushed;
    logic                     r_reqcyc;
    logic [63:0]              r_req;
    logic [BUS_TAG_WIDTH-1:0] r_reqtag;
    logic [31:0]              r_instr;
    logic [63:0]              r_instr_pc;

    logic [63:0] w_pc_aligned;
    logic        w_start;
    logic        w_beat_acc;
    logic        w_last_beat;
    logic        w_drop;
    logic        w_hit;
    logic [31:0] w_lb_word;
    logic [31:0] w_fill_word;
    logic [2:0]  w_rd_idx;
    logic        w_rd_hi;
    logic [57:0] w_tag;
    logic        w_unused;

    assign w_pc_aligned = {pc_in[63:2], 2'b00};
    assign w_start      = (r_state == S_IDLE) && fetch_en && !flush;
    assign w_beat_acc   = (r_state == S_FILL) && bus_respcyc;
    assign w_last_beat  = w_beat_acc && (r_beat_cnt == 3'(LINE_BEATS - 1));
    // A flush seen anywhere during the request/fill suppresses the delivery.
    assign w_drop       = r_flushed || flush;

    // In IDLE the buffer is probed with the incoming PC; afterwards with the latched one.
    assign w_rd_idx = (r_state == S_IDLE) ? pc_in[5:3]     : r_cur_pc[5:3];
    assign w_rd_hi  = (r_state == S_IDLE) ? pc_in[2]       : r_cur_pc[2];
    assign w_tag    = (r_state == S_IDLE) ? pc_in[63:6]    : r_cur_pc[63:6];

    // The last beat is still being written when the instruction is captured, so bypass it.
    assign w_fill_word = (r_cur_pc[5:3] == 3'(LINE_BEATS - 1)) ?
                         sel_word(bus_resp, r_cur_pc[2]) : w_lb_word;

    assign w_unused = ^{bus_resptag, pc_in[1:0]};

    ifetch_linebuf u_linebuf (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (w_beat_acc),
        .i_wr_idx  (r_beat_cnt),
        .i_wr_data (bus_resp),
        .i_inval   (w_start && !w_hit),
        .i_install (w_last_beat),
        .i_tag     (w_tag),
        .i_rd_idx  (w_rd_idx),
        .i_rd_hi   (w_rd_hi),
        .o_rd_word (w_lb_word),
        .o_hit     (w_hit)
    );

    // Next-state decision for the fetch FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = w_hit ? S_DELIVER : S_REQ;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus_reqack) begin
                    w_next = S_FILL;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_FILL: begin
                if (w_last_beat) begin
                    w_next = w_drop ? S_IDLE : S_DELIVER;
                end else begin
                    w_next = S_FILL;
                end
            end
            S_DELIVER: begin
                if (flush || !stall) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DELIVER;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // FSM state, request registers, beat counter and captured instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cur_pc   <= 64'd0;
            r_beat_cnt <= 3'd0;
            r_flushed  <= 1'b0;
            r_reqcyc   <= 1'b0;
            r_req      <= 64'd0;
            r_reqtag   <= '0;
            r_instr    <= 32'd0;
            r_instr_pc <= 64'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cur_pc <= w_pc_aligned;
                        if (w_hit) begin
                            r_instr    <= w_lb_word;
                            r_instr_pc <= w_pc_aligned;
                        end else begin
                            r_reqcyc   <= 1'b1;
                            r_req      <= {pc_in[63:LINE_OFF_BITS], {LINE_OFF_BITS{1'b0}}};
                            r_reqtag   <= BUS_TAG_WIDTH'(TAG_READ);
                            r_flushed  <= 1'b0;
                            r_beat_cnt <= 3'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (bus_reqack) begin
                        r_reqcyc <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (w_beat_acc) begin
                        r_beat_cnt <= r_beat_cnt + 3'd1;
                    end
                    if (w_last_beat && !w_drop) begin
                        r_instr    <= w_fill_word;
                        r_instr_pc <= r_cur_pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sig_recvd   = (r_state == S_DELIVER) && !flush;
    assign bus_respack = w_beat_acc;
    assign bus_reqcyc  = r_reqcyc;
    assign bus_req     = r_req;
    assign bus_reqtag  = r_reqtag;
    assign instr_out   = r_instr;
    assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_ifetch_line_fill.sv
// Self-checking bench for ifetch_line_fill with a behavioural memory and line-buffer model.
// Hit expectations follow IFETCH_LINEBUF_EN when it is defined for the build.
module tb_ifetch_line_fill;
    import ifetch_pkg::*;

`ifdef IFETCH_LINEBUF_EN
    localparam bit LB_EN = 1'b1;
`else
    localparam bit LB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [63:0] pc_in = 64'd0;
    logic        fetch_en = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] instr_out;
    logic [63:0] instr_pc;
    logic        sig_recvd, bus_reqcyc, bus_respack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack = 1'b0, bus_respcyc = 1'b0;
    logic [63:0] bus_resp = 64'd0;
    logic [12:0] bus_resptag = 13'h0001;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch_line_fill dut (
        .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .fetch_en(fetch_en),
        .stall(stall), .flush(flush), .instr_out(instr_out), .instr_pc(instr_pc),
        .sig_recvd(sig_recvd), .bus_reqcyc(bus_reqcyc), .bus_req(bus_req),
        .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
    );

    always #5 clk = ~clk;

    // Memory: 64-bit beats keyed by beat address, filled with random data on first use.
    logic [63:0] mem [logic [63:0]];
    bit          mdl_valid = 1'b0;
    logic [63:0] mdl_line  = 64'd0;

    function automatic logic [63:0] get_beat(input logic [63:0] a);
        if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
        return mem[a];
    endfunction

    function automatic logic [31:0] exp_instr(input logic [63:0] pc);
        logic [63:0] beat;
        beat = get_beat(pc - (pc % 64'd8));
        return ((pc % 64'd8) >= 64'd4) ? beat[63:32] : beat[31:0];
    endfunction

    function automatic bit mdl_hit(input logic [63:0] pc);
        return LB_EN && mdl_valid && (mdl_line == pc / 64'd64);
    endfunction

    task automatic mdl_fill(input logic [63:0] pc);
        mdl_valid = 1'b1;
        mdl_line  = pc / 64'd64;
    endtask

    // Observations of one fetch, filled in by drive_fetch.
    bit          ob_req_seen, ob_req_unstable, ob_recvd, ob_hold_bad, ob_timeout;
    bit          ob_post_recvd, ob_flush_drop_bad;
    int          ob_acks, ob_beats, ob_first_req_cyc, ob_recvd_cyc, ob_last_beat_cyc;
    int          ob_hold_cycles, ob_req_cycles;
    logic [63:0] ob_req_addr, ob_pc;
    logic [12:0] ob_req_tag;
    logic [31:0] ob_instr;

    // Issues one fetch and plays memory on the bus; cycle 0 is the fetch_en cycle.
    task automatic drive_fetch(input logic [63:0] pc, input int ack_dly, input int max_gap,
                               input int stall_n, input int flush_beat, input bit flush_dlv);
        int cyc = 0, wait_cnt = 0, gap = 0, beat_idx = 0, stall_left = stall_n, post = 0;
        bit acked = 0, done = 0, fl_sent = 0, prev_recvd = 0;
        ob_req_seen = 0; ob_req_unstable = 0; ob_recvd = 0; ob_hold_bad = 0;
        ob_flush_drop_bad = 0; ob_acks = 0; ob_beats = 0; ob_first_req_cyc = -1;
        ob_recvd_cyc = -1; ob_last_beat_cyc = -1; ob_hold_cycles = 0; ob_req_cycles = 0;
        ob_req_addr = 64'd0; ob_req_tag = 13'd0; ob_instr = 32'd0; ob_pc = 64'd0;
        @(negedge clk);
        pc_in = pc; fetch_en = 1'b1; stall = 1'b0; flush = 1'b0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            fetch_en = 1'b0; flush = 1'b0; bus_reqack = 1'b0; bus_respcyc = 1'b0;
            bus_resp = 64'd0;
            stall = (stall_left > 0);
            if (bus_reqcyc) begin
                ob_req_cycles++;
                if (!ob_req_seen) begin
                    ob_req_seen = 1; ob_first_req_cyc = cyc;
                    ob_req_addr = bus_req; ob_req_tag = bus_reqtag;
                end else if (bus_req !== ob_req_addr || bus_reqtag !== ob_req_tag) begin
                    ob_req_unstable = 1;
                end
                bus_reqack = (wait_cnt >= ack_dly);
                wait_cnt++;
            end
            if (acked && beat_idx < 8) begin
                if (gap > 0) gap--;
                else begin
                    bus_respcyc = 1'b1;
                    bus_resp = get_beat(ob_req_addr + 64'(8 * beat_idx));
                end
            end
            if (flush_beat >= 0 && !fl_sent && acked && beat_idx == flush_beat) begin
                flush = 1'b1; fl_sent = 1;
            end
            if (flush_dlv && prev_recvd) flush = 1'b1;
            #1;
            if (bus_reqcyc && bus_reqack) begin ob_acks++; acked = 1; end
            if (bus_respcyc && bus_respack) begin
                beat_idx++; ob_beats++; ob_last_beat_cyc = cyc;
                gap = int'($urandom_range(max_gap, 0));
            end
            if (flush_dlv && prev_recvd) begin
                ob_flush_drop_bad = sig_recvd; done = 1;
            end else if (sig_recvd) begin
                if (!ob_recvd) begin
                    ob_recvd = 1; ob_instr = instr_out; ob_pc = instr_pc; ob_recvd_cyc = cyc;
                end else if (instr_out !== ob_instr || instr_pc !== ob_pc) begin
                    ob_hold_bad = 1;
                end
                if (stall) begin ob_hold_cycles++; stall_left--; end
                else done = 1;
            end
            prev_recvd = sig_recvd;
            if (flush_beat >= 0 && ob_beats == 8) begin
                post++;
                if (post > 3) done = 1;
            end
        end
        ob_timeout = !done;
        @(negedge clk);
        fetch_en = 1'b0; stall = 1'b0; flush = 1'b0; bus_reqack = 1'b0; bus_respcyc = 1'b0;
        #1;
        ob_post_recvd = sig_recvd;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mdl_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if ({sig_recvd, bus_reqcyc, bus_respack, bus_req, bus_reqtag, instr_out, instr_pc} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: recvd=%b reqcyc=%b respack=%b req=%h tag=%h instr=%h pc=%h, required all 0",
                         i, sig_recvd, bus_reqcyc, bus_respack, bus_req, bus_reqtag, instr_out, instr_pc);
            end
        end
    endtask

    task automatic test_idle_bus();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_respcyc = 1'b1; bus_resp = {$urandom, $urandom};
            #1;
            n_tests++;
            if (bus_respack !== 1'b0 || sig_recvd !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_bus: respack=%b recvd=%b, required 0/0", bus_respack, sig_recvd);
            end
        end
        @(negedge clk);
        bus_respcyc = 1'b0;
    endtask

    task automatic test_miss();
        mem[64'h1000] = {32'h00A00093, 32'h00000013};
        drive_fetch(64'h1004, 0, 0, 0, -1, 0);
        n_tests++; if (ob_timeout) begin n_fail++; $display("FAIL miss_timeout: no delivery within budget"); end
        n_tests++; if (ob_req_addr !== 64'h1000 || ob_first_req_cyc != 1) begin n_fail++;
            $display("FAIL miss_req: addr=%h cyc=%0d, required 1000 at cycle 1", ob_req_addr, ob_first_req_cyc); end
        n_tests++; if (ob_req_tag !== TAG_READ) begin n_fail++;
            $display("FAIL miss_tag: got %h, required %h", ob_req_tag, TAG_READ); end
        n_tests++; if (ob_beats != 8 || ob_acks != 1) begin n_fail++;
            $display("FAIL miss_beats: beats=%0d acks=%0d, required 8/1", ob_beats, ob_acks); end
        n_tests++; if (ob_instr !== 32'h00A00093 || ob_pc !== 64'h1004) begin n_fail++;
            $display("FAIL miss_instr: instr=%h pc=%h, required 00a00093/1004", ob_instr, ob_pc); end
        n_tests++; if (ob_recvd_cyc != ob_last_beat_cyc + 1 || ob_post_recvd !== 1'b0) begin n_fail++;
            $display("FAIL miss_latency: recvd at %0d last beat %0d post=%b, required B+1 and 0",
                     ob_recvd_cyc, ob_last_beat_cyc, ob_post_recvd); end
        mdl_fill(64'h1004);
    endtask

    task automatic test_stall_hold();
        logic [63:0] pc;
        pc = 64'h4000 + 64'(4 * $urandom_range(15, 0));
        drive_fetch(pc, 1, 2, 5, -1, 0);
        n_tests++; if (ob_timeout || ob_hold_cycles != 5 || ob_hold_bad) begin n_fail++;
            $display("FAIL stall_hold: timeout=%b held=%0d changed=%b, required 0/5/0",
                     ob_timeout, ob_hold_cycles, ob_hold_bad); end
        n_tests++; if (ob_instr !== exp_instr(pc) || ob_pc !== pc) begin n_fail++;
            $display("FAIL stall_instr: instr=%h pc=%h, required %h/%h", ob_instr, ob_pc, exp_instr(pc), pc); end
        n_tests++; if (ob_post_recvd !== 1'b0) begin n_fail++;
            $display("FAIL stall_release: recvd=%b after stall dropped, required 0", ob_post_recvd); end
        mdl_fill(pc);
    endtask

    task automatic test_flush_fill();
        bit exp_hit;
        drive_fetch(64'h1000, 0, 1, 0, 3, 0);
        n_tests++; if (ob_timeout || ob_beats != 8 || ob_recvd || ob_acks != 1) begin n_fail++;
            $display("FAIL flush_fill: timeout=%b beats=%0d recvd=%b acks=%0d, required 0/8/0/1",
                     ob_timeout, ob_beats, ob_recvd, ob_acks); end
        mdl_fill(64'h1000);
        exp_hit = mdl_hit(64'h1008);
        drive_fetch(64'h1008, 0, 0, 0, -1, 0);
        n_tests++; if (ob_req_seen != !exp_hit || (!exp_hit && ob_req_addr !== 64'h1000)) begin n_fail++;
            $display("FAIL flush_refetch_req: req_seen=%b addr=%h, required %b/1000", ob_req_seen, ob_req_addr, !exp_hit); end
        n_tests++; if (ob_recvd_cyc != (exp_hit ? 1 : ob_last_beat_cyc + 1)) begin n_fail++;
            $display("FAIL flush_refetch_latency: recvd at %0d, hit=%b last beat %0d", ob_recvd_cyc, exp_hit, ob_last_beat_cyc); end
        n_tests++; if (ob_instr !== exp_instr(64'h1008) || ob_pc !== 64'h1008) begin n_fail++;
            $display("FAIL flush_refetch_instr: instr=%h pc=%h, required %h/1008", ob_instr, ob_pc, exp_instr(64'h1008)); end
        mdl_fill(64'h1008);
    endtask

    task automatic test_seq_hits();
        logic [63:0] pcs [2];
        bit exp_hit;
        pcs[0] = 64'h103C; pcs[1] = 64'h1040;
        for (int i = 0; i < 2; i++) begin
            exp_hit = mdl_hit(pcs[i]);
            drive_fetch(pcs[i], 0, 1, 0, -1, 0);
            n_tests++; if (ob_timeout || ob_req_seen != !exp_hit ||
                           (!exp_hit && ob_req_addr !== pcs[i] - (pcs[i] % 64'd64))) begin n_fail++;
                $display("FAIL seq_req pc=%h: timeout=%b req_seen=%b addr=%h, expected hit=%b",
                         pcs[i], ob_timeout, ob_req_seen, ob_req_addr, exp_hit); end
            n_tests++; if (ob_instr !== exp_instr(pcs[i]) || ob_pc !== pcs[i]) begin n_fail++;
                $display("FAIL seq_instr pc=%h: instr=%h pc=%h, required %h", pcs[i], ob_instr, ob_pc, exp_instr(pcs[i])); end
            mdl_fill(pcs[i]);
        end
    endtask

    task automatic test_delayed_ack();
        logic [63:0] pc;
        pc = 64'h5000 + 64'(4 * $urandom_range(15, 0));
        drive_fetch(pc, 4, 0, 0, -1, 0);
        n_tests++; if (ob_timeout || ob_req_cycles != 5 || ob_req_unstable || ob_acks != 1) begin n_fail++;
            $display("FAIL delayed_ack: timeout=%b req_cycles=%0d unstable=%b acks=%0d, required 0/5/0/1",
                     ob_timeout, ob_req_cycles, ob_req_unstable, ob_acks); end
        n_tests++; if (ob_req_tag !== TAG_READ || ob_req_addr !== 64'h5000) begin n_fail++;
            $display("FAIL delayed_ack_req: tag=%h addr=%h, required %h/5000", ob_req_tag, ob_req_addr, TAG_READ); end
        n_tests++; if (ob_instr !== exp_instr(pc)) begin n_fail++;
            $display("FAIL delayed_ack_instr: got %h, required %h", ob_instr, exp_instr(pc)); end
        mdl_fill(pc);
    endtask

    task automatic test_flush_deliver();
        drive_fetch(64'h6008, 0, 0, 3, -1, 1);
        n_tests++; if (ob_timeout || !ob_recvd || ob_flush_drop_bad || ob_post_recvd) begin n_fail++;
            $display("FAIL flush_deliver: timeout=%b recvd=%b still_high=%b post=%b, required 0/1/0/0",
                     ob_timeout, ob_recvd, ob_flush_drop_bad, ob_post_recvd); end
        mdl_fill(64'h6008);
    endtask

    task automatic test_midfill_reset();
        @(negedge clk);
        pc_in = 64'h2000; fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0; bus_reqack = 1'b1;
        #1;
        n_tests++; if (bus_reqcyc !== 1'b1 || bus_req !== 64'h2000) begin n_fail++;
            $display("FAIL midfill_req: reqcyc=%b addr=%h, required 1/2000", bus_reqcyc, bus_req); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_reqack = 1'b0; bus_respcyc = 1'b1; bus_resp = get_beat(64'h2000 + 64'(8 * i));
        end
        @(negedge clk);
        bus_respcyc = 1'b0; reset_n = 1'b0;
        #1;
        n_tests++; if ({sig_recvd, bus_reqcyc, bus_respack, bus_req} !== '0) begin n_fail++;
            $display("FAIL midfill_reset_outputs: recvd=%b reqcyc=%b respack=%b req=%h, required 0",
                     sig_recvd, bus_reqcyc, bus_respack, bus_req); end
        @(negedge clk);
        reset_n = 1'b1;
        mdl_valid = 1'b0;
        drive_fetch(64'h2008, 0, 1, 0, -1, 0);
        n_tests++; if (ob_timeout || ob_acks != 1 || ob_req_addr !== 64'h2000) begin n_fail++;
            $display("FAIL midfill_refetch: timeout=%b acks=%0d addr=%h, required 0/1/2000", ob_timeout, ob_acks, ob_req_addr); end
        n_tests++; if (ob_instr !== exp_instr(64'h2008)) begin n_fail++;
            $display("FAIL midfill_instr: got %h, required %h", ob_instr, exp_instr(64'h2008)); end
        mdl_fill(64'h2008);
    endtask

    task automatic test_random();
        logic [63:0] pc;
        bit exp_hit;
        for (int i = 0; i < 12; i++) begin
            pc = 64'h8000 + 64'(64 * $urandom_range(2, 0)) + 64'($urandom_range(63, 0));
            exp_hit = mdl_hit(pc);
            drive_fetch(pc, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                        int'($urandom_range(3, 0)), -1, 0);
            n_tests++; if (ob_timeout || ob_acks != (exp_hit ? 0 : 1)) begin n_fail++;
                $display("FAIL rand_bus[%0d] pc=%h: timeout=%b acks=%0d, expected hit=%b", i, pc, ob_timeout, ob_acks, exp_hit); end
            n_tests++; if (ob_instr !== exp_instr(pc)) begin n_fail++;
                $display("FAIL rand_instr[%0d] pc=%h: got %h, required %h", i, pc, ob_instr, exp_instr(pc)); end
            n_tests++; if (ob_pc !== pc - (pc % 64'd4)) begin n_fail++;
                $display("FAIL rand_pc[%0d]: got %h, required %h", i, ob_pc, pc - (pc % 64'd4)); end
            n_tests++; if (ob_recvd_cyc != (exp_hit ? 1 : ob_last_beat_cyc + 1)) begin n_fail++;
                $display("FAIL rand_latency[%0d]: recvd at %0d, last beat %0d, hit=%b", i, ob_recvd_cyc, ob_last_beat_cyc, exp_hit); end
            if (!exp_hit) mdl_fill(pc);
        end
    endtask

    initial begin
        test_reset();
        test_idle_bus();
        test_miss();
        test_stall_hold();
        test_flush_fill();
        test_seq_hits();
        test_delayed_ack();
        test_flush_deliver();
        test_midfill_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
